// File: rtl/ccg_resp_compactor.sv
// ccg_resp_compactor
// Folds CUT response vectors into a MISR, one vector per valid/ready handshake.
// After num_patterns vectors it holds the final signature and a pass/fail
// verdict against exp_sig.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         begin a run (honoured in IDLE and DONE only)
//   abort         return to IDLE from any state, no verdict
//   num_patterns  vectors per run, latched on accepted start
//   exp_sig       expected signature, latched on accepted start
//   resp_valid    resp carries a CUT output vector
//   resp          CUT output vector, f1 at bit 0
//   resp_ready    vector accepted this cycle (CAPTURE only)
//   busy          run in progress
//   done          run complete, sig final
//   pass          final sig matched exp_sig, meaningful while done=1
//   sig           current MISR contents
module ccg_resp_compactor #(
  parameter int               RESP_W = 26,
  parameter int               SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED   = 32'h00000000,
  parameter int               CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [SIG_W-1:0]  exp_sig,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp,
  output logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  sig
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, num_q;
  logic [SIG_W-1:0]   exp_q;
  logic [SIG_W-1:0]   resp_ext;
  logic [SIG_W-1:0]   sig_step;
  logic               xfer, last;

  // Zero-extend without a replication that would be zero-width when RESP_W == SIG_W.
  always_comb begin
    resp_ext               = '0;
    resp_ext[RESP_W-1:0]   = resp;
  end

  assign sig_step = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ resp_ext;
  // abort wins over a same-cycle transfer, so it must not count as one.
  assign xfer     = (state == CAPTURE) && resp_valid && !abort;
  // num_q is never 0 in CAPTURE, so the decrement cannot underflow here.
  assign last     = (cnt == num_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    resp_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_nxt = (num_patterns == '0) ? DONE : CAPTURE;
      end
      CAPTURE: begin
        resp_ready = 1'b1;
        busy       = 1'b1;
        if (xfer && last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig   <= SEED;
      cnt   <= '0;
      num_q <= '0;
      exp_q <= '0;
      pass  <= 1'b0;
    end else if (abort) begin
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            num_q <= num_patterns;
            exp_q <= exp_sig;
            sig   <= SEED;
            cnt   <= '0;
            // A zero-length run finishes immediately on the seed.
            pass  <= (num_patterns == '0) && (SEED == exp_sig);
          end
        end
        CAPTURE: begin
          if (xfer) begin
            sig <= sig_step;
            cnt <= cnt + CNT_W'(1);
            if (last) pass <= (sig_step == exp_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccg_resp_compactor.sv
module tb_ccg_resp_compactor;

  logic        clk = 1'b0;
  logic        rst, start, abort, resp_valid;
  logic [15:0] num_patterns;
  logic [31:0] exp_sig;
  logic [25:0] resp;
  logic        resp_ready, busy, done, pass;
  logic [31:0] sig;

  int passes = 0;
  int total  = 0;

  ccg_resp_compactor dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_patterns(num_patterns), .exp_sig(exp_sig),
    .resp_valid(resp_valid), .resp(resp), .resp_ready(resp_ready),
    .busy(busy), .done(done), .pass(pass), .sig(sig)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; resp_valid = 1'b0;
    num_patterns = '0; exp_sig = '0; resp = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", resp_ready, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_pass",  pass, 0);
    chk("rst_sig",   sig, 32'h0);

    // single vector
    start = 1'b1; num_patterns = 16'd1; exp_sig = 32'h1;
    tick(); start = 1'b0;
    chk("t1_busy",  busy, 1);
    chk("t1_ready", resp_ready, 1);
    resp_valid = 1'b1; resp = 26'h1;
    tick(); resp_valid = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_busy_off", busy, 0);
    chk("t1_sig",  sig, 32'h00000001);
    chk("t1_pass", pass, 1);

    // two vectors with a gap, restart from DONE
    start = 1'b1; num_patterns = 16'd2; exp_sig = 32'h3;
    tick(); start = 1'b0;
    resp_valid = 1'b1; resp = 26'h1;
    tick(); resp_valid = 1'b0;
    chk("t2_sig1", sig, 32'h1);
    tick();
    chk("t2_gap_sig",  sig, 32'h1);
    chk("t2_gap_done", done, 0);
    resp_valid = 1'b1;
    tick(); resp_valid = 1'b0;
    chk("t2_sig",  sig, 32'h3);
    chk("t2_done", done, 1);
    chk("t2_pass", pass, 1);

    // feedback: walk a bit up to the MSB, then shift it out into POLY
    start = 1'b1; num_patterns = 16'd8; exp_sig = 32'h0;
    tick(); start = 1'b0;
    resp_valid = 1'b1; resp = 26'h2000000;
    tick(); resp = 26'h0;
    for (int i = 0; i < 6; i++) tick();
    resp_valid = 1'b0;
    chk("t3_msb", sig, 32'h80000000);
    chk("t3_notdone", done, 0);
    resp_valid = 1'b1;
    tick(); resp_valid = 1'b0;
    chk("t3_sig",  sig, 32'h04C11DB7);
    chk("t3_pass", pass, 0);
    chk("t3_done", done, 1);

    // zero count
    start = 1'b1; num_patterns = 16'd0; exp_sig = 32'h0;
    tick(); start = 1'b0;
    chk("t4_done",  done, 1);
    chk("t4_pass",  pass, 1);
    chk("t4_ready", resp_ready, 0);
    chk("t4_sig",   sig, 32'h0);

    // abort in DONE clears done and pass
    abort = 1'b1;
    tick(); abort = 1'b0;
    chk("t5_done", done, 0);
    chk("t5_pass", pass, 0);

    // abort mid-run with a valid vector on the same cycle
    start = 1'b1; num_patterns = 16'd4; exp_sig = 32'h0;
    tick(); start = 1'b0;
    resp_valid = 1'b1; resp = 26'h5;
    tick();
    resp = 26'h7; abort = 1'b1;
    tick(); abort = 1'b0; resp_valid = 1'b0;
    chk("t5_busy",  busy, 0);
    chk("t5_ready", resp_ready, 0);
    chk("t5_sig",   sig, 32'h5);
    chk("t5_done2", done, 0);
    start = 1'b1; num_patterns = 16'd2;
    tick(); start = 1'b0;
    chk("t5_reseed", sig, 32'h0);

    // reset mid-capture, then a fresh run
    resp_valid = 1'b1; resp = 26'h10;
    tick(); resp_valid = 1'b0;
    chk("t6_pre", sig, 32'h10);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_sig",  sig, 32'h0);
    start = 1'b1; num_patterns = 16'd1; exp_sig = 32'h03FFFFFF;
    tick(); start = 1'b0;
    resp_valid = 1'b1; resp = 26'h3FFFFFF;
    tick(); resp_valid = 1'b0;
    chk("t6_sig2", sig, 32'h03FFFFFF);
    chk("t6_done", done, 1);
    chk("t6_pass", pass, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/ccg_resp_compactor.md
# ccg_resp_compactor

Sequential response compactor that sits directly downstream of a generated combinational benchmark circuit (CUT). It accepts one CUT output vector per handshake and folds it into a multiple-input signature register (MISR). After a programmed number of vectors it reports the final signature and a pass/fail verdict against an expected signature. It is the capture half of the benchmark BIST harness; each CUT instance gets one compactor.

## Interface
Parameters:
- RESP_W, 26: width of CUT response vector (f1..fN packed, f1 at bit 0); must be ≤ SIG_W
- SIG_W, 32: MISR width
- POLY, 32'h04C11DB7: feedback polynomial, bit i set = tap into bit i
- SEED, 32'h00000000: MISR value loaded on start
- CNT_W, 16: pattern counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled in IDLE and DONE only
- abort  in  1  return to IDLE from any state; no verdict produced
- num_patterns  in  CNT_W  vectors to compact; latched on accepted start
- exp_sig  in  SIG_W  expected signature; latched on accepted start
- resp_valid  in  1  resp holds a valid CUT output vector
- resp  in  RESP_W  CUT output vector
- resp_ready  out  1  compactor accepts a vector this cycle
- busy  out  1  state is CAPTURE
- done  out  1  run complete, signature final
- pass  out  1  final signature equals latched exp_sig; valid only while done=1
- sig  out  SIG_W  current MISR contents

## Operation
- States: IDLE, CAPTURE, DONE.
- IDLE: resp_ready=0. When start=1, latch num_patterns and exp_sig, load sig=SEED, clear cnt, then go to CAPTURE. If num_patterns=0, go straight to DONE with sig=SEED and pass=(SEED==exp_sig).
- CAPTURE: resp_ready=1. A transfer occurs when resp_valid & resp_ready. On a transfer:
  - sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(resp)
  - cnt increments.
  - If cnt == latched_num-1, go to DONE and register pass = (sig_next == latched_exp).
  - A cycle with no transfer leaves sig and cnt unchanged. Gaps are allowed.
  - start is ignored in CAPTURE.
- DONE: done=1, resp_ready=0. sig, pass and done hold. start=1 restarts exactly as from IDLE: the next cycle is CAPTURE, or DONE for a zero count.
- abort=1 in any state: go to IDLE next cycle and clear done and pass. sig holds its value. abort takes priority over start and over a same-cycle transfer; that transfer is not compacted.
- Arithmetic: cnt is unsigned CNT_W and never wraps within a run, because the maximum run is 2^CNT_W-1 vectors.

## Timing
- Reset values: state=IDLE, sig=SEED, cnt=0, resp_ready=0, busy=0, done=0, pass=0.
- Reset takes priority over all inputs, including mid-CAPTURE. The partial signature is discarded.
- start accepted at edge k: busy=1 and resp_ready=1 from cycle k+1.
- Transfer at edge k: sig reflects it from cycle k+1.
- Final transfer at edge k: done=1, pass valid and busy=0 at cycle k+1. A run of N vectors with no gaps takes N+1 cycles from start to done.
- resp_ready depends only on state and never on resp_valid, so there is no combinational path from input to ready.
- pass and done are registered. sig is a direct register output.

## Test plan
- Single vector, no feedback: SEED=0, num_patterns=1, resp=26'h1, exp_sig=32'h1 → one cycle later done=1, sig=32'h00000001, pass=1.
- Two vectors with a one-cycle valid gap: SEED=0, num=2, resp=1 then 1 → sig=32'h00000003, and done rises exactly one cycle after the second transfer.
- Feedback tap: SEED=32'h80000000, num=1, resp=0, exp_sig=0 → sig=32'h04C11DB7, pass=0, done=1.
- Zero count: num_patterns=0, exp_sig=SEED → done=1 the cycle after start with pass=1, and resp_ready is never asserted.
- abort mid-run: num=4, abort asserted with valid on the 2nd vector → next cycle state=IDLE, done=0, pass=0, sig equal to the value after the 1st vector only. Then start a new run → sig reloads SEED.
- rst asserted during CAPTURE, then start with num=1, resp=26'h3FFFFFF, SEED=0 → sig=32'h03FFFFFF, which confirms no stale state survives reset.
